// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM encoding and default timeout.
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } wbm_state_t;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone initiator: one classic cyc/we/ack cycle per stream command, with a
// timeout abort and a held response. Tolerates registered-ack slaves.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_we,
  output logic          wb_cyc,
  input  logic          wb_ack,
  input  logic [DW-1:0] wb_rdata,
  output logic          busy,
  output logic [7:0]    err_cnt
);

  localparam logic [TW-1:0] CNT_LIMIT = TW'(TIMEOUT);
  localparam logic [TW-1:0] CNT_ONE   = TW'(1);

  wbm_state_t    r_state;
  logic [TW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_cyc;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;
  logic [7:0]    r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_we    <= cmd_we;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (wb_ack) begin
            r_rsp_rdata <= r_we ? '0 : wb_rdata;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end else if (r_cnt == CNT_LIMIT) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            r_state     <= ST_RSP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_RSP: begin
          // Spending at least this state with cyc low lets a registered ack fall.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign wb_addr   = r_addr;
  assign wb_wdata  = r_wdata;
  assign wb_we     = r_we;
  assign wb_cyc    = r_cyc;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: registered-ack slave on a TIMEOUT=4 instance,
// hand-driven ack on a TIMEOUT=2 instance.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, wb_we, wb_cyc, wb_ack, busy;
  logic [31:0] rsp_rdata, wb_wdata, wb_rdata;
  logic [7:0]  wb_addr, err_cnt;

  logic        b_cmd_valid = 1'b0, b_rsp_ready = 1'b0, b_ack = 1'b0;
  logic [7:0]  b_cmd_addr = '0;
  logic [31:0] b_rdata_in = '0;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_wb_we, b_wb_cyc, b_busy;
  logic [31:0] b_rsp_rdata, b_wb_wdata;
  logic [7:0]  b_wb_addr, b_err_cnt;

  // Slave model: ack = cyc & ~ack, data valid only in the ack cycle.
  logic        s_en = 1'b0, s_stray = 1'b0, s_ack = 1'b0;
  logic [31:0] s_data = '0, s_wd = '0;
  logic [7:0]  s_wa = '0;
  always @(posedge clk) begin
    s_ack <= s_en & wb_cyc & ~s_ack;
    if (s_ack && wb_cyc && wb_we) begin
      s_wa <= wb_addr;
      s_wd <= wb_wdata;
    end
  end
  assign wb_ack   = s_ack | s_stray;
  assign wb_rdata = s_ack ? s_data : 32'h5A5A5A5A;  // stands in for X outside the ack cycle

  always #5 clk = ~clk;

  wb_cmd_master #(.AW(8), .DW(32), .TIMEOUT(4), .TW(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_ack(wb_ack), .wb_rdata(wb_rdata), .busy(busy), .err_cnt(err_cnt)
  );

  wb_cmd_master #(.AW(8), .DW(32), .TIMEOUT(2), .TW(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_we(1'b0),
    .cmd_addr(b_cmd_addr), .cmd_wdata(32'h0),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .wb_addr(b_wb_addr), .wb_wdata(b_wb_wdata), .wb_we(b_wb_we), .wb_cyc(b_wb_cyc),
    .wb_ack(b_ack), .wb_rdata(b_rdata_in), .busy(b_busy), .err_cnt(b_err_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the TIMEOUT=4 instance and consume its response.
  task automatic do_cmd(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int cyc_n, output int lat, output int we_bad, output int addr_bad);
    cyc_n = 0; lat = 0; we_bad = 0; addr_bad = 0;
    cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 50) begin
      if (wb_cyc) begin
        cyc_n++;
        if (wb_we !== we) we_bad++;
        if (wb_addr !== addr) addr_bad++;
      end
      tick();
      lat++;
    end
    rdata = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, held;
    logic er;
    int cn, lt, wb, ab, nr, ncyc, run, maxrun, viol;
    logic [7:0] ec0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: write with registered-ack slave
    s_en = 1'b1; s_data = 32'h11111111;
    do_cmd(1'b1, 8'h01, 32'h00000A05, rd, er, cn, lt, wb, ab);
    chk("wr_cyc_cycles", 32'(cn), 32'd2);
    chk("wr_latency", 32'(lt), 32'd2);
    chk("wr_we_during_cyc", 32'(wb), 32'd0);
    chk("wr_addr_during_cyc", 32'(ab), 32'd0);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_slave_addr", 32'(s_wa), 32'h01);
    chk("wr_slave_data", s_wd, 32'h00000A05);
    chk("wr_rsp_dropped", 32'(rsp_valid), 32'd0);

    // 2: read, data valid only in ack cycle
    s_data = 32'hDEADBEEF;
    do_cmd(1'b0, 8'h07, 32'hFFFFFFFF, rd, er, cn, lt, wb, ab);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);
    chk("rd_we_low", 32'(wb), 32'd0);
    chk("rd_cyc_cycles", 32'(cn), 32'd2);

    // 3: timeouts against a silent slave
    s_en = 1'b0;
    do_cmd(1'b0, 8'h0F, 32'h0, rd, er, cn, lt, wb, ab);
    chk("to_cyc_cycles", 32'(cn), 32'd5);
    chk("to_err", 32'(er), 32'd1);
    chk("to_rdata", rd, 32'd0);
    chk("to_err_cnt_1", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 299; i++) do_cmd(1'b0, 8'h0F, 32'h0, rd, er, cn, lt, wb, ab);
    chk("to_err_cnt_sat", 32'(err_cnt), 32'd255);

    // 4a: back-to-back, rsp_ready tied high
    s_en = 1'b1; s_data = 32'h0000BEEF;
    cmd_we = 1'b0; cmd_addr = 8'h03; cmd_valid = 1'b1; rsp_ready = 1'b1;
    nr = 0; ncyc = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 16; i++) begin
      if (cmd_ready) nr++;
      if (wb_cyc) begin ncyc++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      if (i == 15) cmd_valid = 1'b0;
      tick();
    end
    rsp_ready = 1'b0;
    chk("b2b_ready_pulses", 32'(nr), 32'd4);
    chk("b2b_cyc_cycles", 32'(ncyc), 32'd8);
    chk("b2b_cyc_max_run", 32'(maxrun), 32'd2);
    chk("b2b_idle_after", 32'(busy), 32'd0);

    // 4b: response held under backpressure
    s_data = 32'h12345678;
    cmd_addr = 8'h05; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lt = 0;
    while (!rsp_valid && lt < 50) begin tick(); lt++; end
    held = rsp_rdata;
    chk("hold_rdata", held, 32'h12345678);
    s_data = 32'h87654321;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || cmd_ready !== 1'b0 || rsp_err !== 1'b0) viol++;
      tick();
    end
    chk("hold_stable", 32'(viol), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold_released", 32'(rsp_valid), 32'd0);

    // 5a: TIMEOUT=2 instance, plain timeout
    b_cmd_addr = 8'h21; b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    cn = 0; lt = 0;
    while (!b_rsp_valid && lt < 20) begin
      if (b_wb_cyc) cn++;
      tick();
      lt++;
    end
    chk("b_to_cyc_cycles", 32'(cn), 32'd3);
    chk("b_to_err", 32'(b_rsp_err), 32'd1);
    chk("b_err_cnt_1", 32'(b_err_cnt), 32'd1);
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;

    // 5b: ack on the exact timeout cycle
    b_cmd_addr = 8'h22; b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    tick();
    tick();
    chk("b_tie_cyc_3rd", 32'(b_wb_cyc), 32'd1);
    chk("b_tie_addr", 32'(b_wb_addr), 32'h22);
    chk("b_tie_we", 32'(b_wb_we), 32'd0);
    chk("b_tie_wdata", b_wb_wdata, 32'd0);
    b_ack = 1'b1; b_rdata_in = 32'hCAFEF00D;
    tick();
    b_ack = 1'b0; b_rdata_in = 32'h0;
    chk("b_tie_valid", 32'(b_rsp_valid), 32'd1);
    chk("b_tie_err", 32'(b_rsp_err), 32'd0);
    chk("b_tie_rdata", b_rsp_rdata, 32'hCAFEF00D);
    chk("b_tie_err_cnt", 32'(b_err_cnt), 32'd1);
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
    chk("b_tie_idle", 32'(b_busy) | (32'(b_cmd_ready) << 1), 32'd2);

    // 5c: stray ack while idle
    ec0 = err_cnt;
    s_stray = 1'b1;
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || wb_cyc !== 1'b0) viol++;
    end
    s_stray = 1'b0;
    tick();
    chk("stray_no_effect", 32'(viol), 32'd0);
    chk("stray_err_cnt", 32'(err_cnt), 32'(ec0));

    // 6: async reset in the middle of a bus cycle
    s_en = 1'b0;
    cmd_we = 1'b1; cmd_addr = 8'h09; cmd_wdata = 32'h0BADF00D; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("ar_pre_cyc", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cyc", 32'(wb_cyc), 32'd0);
    chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_wb_addr", 32'(wb_addr), 32'd0);
    chk("ar_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) viol++;
    end
    chk("ar_no_response", 32'(viol), 32'd0);
    s_en = 1'b1;
    do_cmd(1'b1, 8'h0A, 32'h00C0FFEE, rd, er, cn, lt, wb, ab);
    chk("ar_next_latency", 32'(lt), 32'd2);
    chk("ar_next_err", 32'(er), 32'd0);
    chk("ar_next_slave_data", s_wd, 32'h00C0FFEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone initiator. It is the bus-master counterpart to the team's register peripherals, such as the misc, e1 and LED blocks.
- Accepts single read/write commands on a valid/ready stream, typically from a debug/UART bridge or the soft-core shim.
- Runs one classic cyc/we/ack cycle per command, with a timeout.
- Returns read data and an error flag on a response stream.
- Tolerates peripherals that use a registered ack (ack = cyc & ~ack) and that hold read data valid only in the ack cycle.

Parameters:
AW, 8, Wishbone address width.
DW, 32, data width for wdata and rdata.
TIMEOUT, 255, number of BUS-state cycles without ack before abort; legal range 1..2^TW-1.
TW, 8, timeout counter width.

Ports:
clk  in  1  system clock
rst_n  in  1  reset (see Interface rules)
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid & ready
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  AW  target address
cmd_wdata  in  DW  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid & ready
rsp_rdata  out  DW  read data; 0 for writes and for timeouts
rsp_err  out  1  1 = transaction timed out
wb_addr  out  AW  bus address
wb_wdata  out  DW  bus write data
wb_we  out  1  bus write strobe qualifier
wb_cyc  out  1  bus cycle request
wb_ack  in  1  bus acknowledge
wb_rdata  in  DW  bus read data
busy  out  1  state != IDLE
err_cnt  out  8  saturating count of timeouts

Interface rules:
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is rst_n.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following immediately, including mid-transaction:
  - state = IDLE.
  - wb_cyc, wb_we, rsp_valid, rsp_err, busy = 0.
  - wb_addr, wb_wdata, rsp_rdata = 0.
  - err_cnt = 0.
  - A dropped cyc in this case needs no completion. Any in-flight command is lost and produces no response.
- All outputs are registered, except cmd_ready and busy, which decode state.
- FSM has three states: IDLE, BUS, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at edge T, latch addr/wdata/we into wb_addr/wb_wdata/wb_we and set wb_cyc = 1, so the bus sees cyc from cycle T+1.
  - Clear the timeout counter, then go to BUS.
- BUS:
  - cmd_ready = 0.
  - Each cycle, when wb_ack = 1:
    - Capture wb_rdata into rsp_rdata if wb_we = 0, else capture 0.
    - rsp_err = 0.
    - Clear wb_cyc and wb_we at the same edge.
    - rsp_valid = 1; go to RSP.
  - Otherwise, if the counter == TIMEOUT:
    - wb_cyc = 0, rsp_rdata = 0, rsp_err = 1, rsp_valid = 1.
    - err_cnt += 1, saturating at 255; go to RSP.
  - Otherwise the counter increments.
  - If ack and timeout occur in the same cycle, ack wins and the response is a success.
- RSP:
  - rsp_valid held with stable rsp_rdata and rsp_err until rsp_ready.
  - On handshake, rsp_valid = 0; go to IDLE.
  - wb_cyc is guaranteed low for at least 1 cycle between transactions, so a registered-ack slave can deassert ack.
- wb_ack is ignored in IDLE and RSP; a stray or late ack has no effect.
- wb_addr and wb_wdata stay stable for the whole cyc period. They may retain their last value after the transaction.
- Latency with a registered-ack slave (ack one cycle after cyc):
  - Command accepted at edge T.
  - cyc high in cycles T+1 and T+2; ack sampled at edge T+2.
  - rsp_valid high from cycle T+3.
- Throughput: at most one command per 4 cycles.
- The timeout measured from first cyc cycle to abort is TIMEOUT+1 cycles.

Decomposition:
- Shared package: state encoding constants (IDLE = 0, BUS = 1, RSP = 2) and the default TIMEOUT constant.
- No sub-module is needed; the timeout counter stays inline.
- Bench-only: reuse a registered-ack slave model that mirrors the peripherals' ack generation.

Test Plan:
1. Write 0x00000A05 to addr 0x01 with the registered-ack slave: wb_cyc high for exactly 2 cycles with wb_we = 1 and wb_addr = 0x01. rsp_valid appears 3 cycles after accept, with rsp_err = 0 and rsp_rdata = 0.
2. Read addr 0x07; slave returns 0xDEADBEEF only in the ack cycle and X otherwise: rsp_rdata = 0xDEADBEEF, rsp_err = 0, wb_we = 0 throughout.
3. Read addr 0x0F with a non-responding slave and TIMEOUT = 4:
   - wb_cyc high for 5 cycles, then drops.
   - rsp_err = 1, rsp_rdata = 0, err_cnt goes 0 -> 1.
   - 300 such timeouts leave err_cnt = 255.
4. Back-to-back commands with cmd_valid held and rsp_ready tied high: cmd_ready pulses once per 4 cycles, and wb_cyc has at least 1 low cycle between transactions. Additionally, rsp_ready held low for 10 cycles: rsp_valid and rsp_rdata stay stable and cmd_ready stays 0.
5. Slave acks on exactly the timeout cycle (TIMEOUT = 2, ack at 3rd cyc cycle): rsp_err = 0, data captured, err_cnt unchanged. A stray ack pulse while IDLE causes no response and no state change.
6. Assert rst_n low during BUS, asynchronously mid-cycle: wb_cyc, rsp_valid and busy go 0 before the next clk edge. After release no response is emitted, and the next command completes normally.
